// File: rtl/mode_scheduler.sv
// Table-driven sequencer for the mode selector's 2-bit mode select.
// Steps through (mode, dwell) slots under start/stop; parks in mode 0 while idle.
module mode_scheduler #(
  parameter int unsigned NUM_SLOTS = 4,
  parameter int unsigned SLOT_W    = $clog2(NUM_SLOTS),
  parameter int unsigned DWELL_W   = 8
) (
  input  logic               clk,
  input  logic               xrst,
  input  logic               cfg_we,
  input  logic [SLOT_W-1:0]  cfg_addr,
  input  logic [1:0]         cfg_mode,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic [SLOT_W-1:0]  cfg_last,
  input  logic               loop,
  input  logic               start,
  input  logic               stop,
  output logic [1:0]         mode,
  output logic [SLOT_W-1:0]  slot,
  output logic               busy,
  output logic               done
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StRun  = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [SLOT_W-1:0]  slot_q, slot_d;
  logic [1:0]         mode_q, mode_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [SLOT_W-1:0]  last_q, last_d;
  logic               loop_q, loop_d;
  logic               done_q, done_d;

  logic [1:0]         tbl_mode_q  [NUM_SLOTS];
  logic [DWELL_W-1:0] tbl_dwell_q [NUM_SLOTS];

  logic               tbl_wr;
  logic               wr_slot0;
  logic [1:0]         first_mode;
  logic [DWELL_W-1:0] first_dwell;
  logic [SLOT_W-1:0]  nxt_slot;

  assign tbl_wr   = cfg_we && (state_q == StIdle);
  assign wr_slot0 = tbl_wr && (cfg_addr == '0);

  // A same-cycle write to slot 0 must be seen by the sequence being started.
  assign first_mode  = wr_slot0 ? cfg_mode  : tbl_mode_q[0];
  assign first_dwell = wr_slot0 ? cfg_dwell : tbl_dwell_q[0];

  assign nxt_slot = (slot_q == last_q) ? '0 : SLOT_W'(slot_q + 1'b1);

  always_ff @(posedge clk) begin
    if (!xrst) begin
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        tbl_mode_q[i]  <= '0;
        tbl_dwell_q[i] <= '0;
      end
    end else if (tbl_wr) begin
      tbl_mode_q[cfg_addr]  <= cfg_mode;
      tbl_dwell_q[cfg_addr] <= cfg_dwell;
    end
  end

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    loop_d  = loop_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          slot_d  = '0;
          mode_d  = first_mode;
          cnt_d   = first_dwell;
          last_d  = cfg_last;
          loop_d  = loop;
        end
      end
      StRun: begin
        if (stop) begin
          state_d = StIdle;
          slot_d  = '0;
          mode_d  = '0;
          cnt_d   = '0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if ((slot_q != last_q) || loop_q) begin
          slot_d = nxt_slot;
          mode_d = tbl_mode_q[nxt_slot];
          cnt_d  = tbl_dwell_q[nxt_slot];
        end else begin
          state_d = StIdle;
          slot_d  = '0;
          mode_d  = '0;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!xrst) begin
      state_q <= StIdle;
      slot_q  <= '0;
      mode_q  <= '0;
      cnt_q   <= '0;
      last_q  <= '0;
      loop_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      loop_q  <= loop_d;
      done_q  <= done_d;
    end
  end

  assign mode = mode_q;
  assign slot = slot_q;
  assign busy = (state_q == StRun);
  assign done = done_q;

endmodule

// File: tb/tb_mode_scheduler.sv
// Bench for mode_scheduler: queue-based reference model checked every cycle,
// directed scenarios with literal traces, then randomized traffic.
module tb_mode_scheduler;

  localparam int NS = 4;
  localparam int SW = 2;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          xrst;
  logic          cfg_we;
  logic [SW-1:0] cfg_addr;
  logic [1:0]    cfg_mode;
  logic [DW-1:0] cfg_dwell;
  logic [SW-1:0] cfg_last;
  logic          loop;
  logic          start;
  logic          stop;
  logic [1:0]    mode;
  logic [SW-1:0] slot;
  logic          busy;
  logic          done;

  int n_checks = 0;
  int n_pass   = 0;

  mode_scheduler #(
    .NUM_SLOTS(NS),
    .DWELL_W  (DW)
  ) dut (
    .clk      (clk),
    .xrst     (xrst),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_mode (cfg_mode),
    .cfg_dwell(cfg_dwell),
    .cfg_last (cfg_last),
    .loop     (loop),
    .start    (start),
    .stop     (stop),
    .mode     (mode),
    .slot     (slot),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference model: the whole run is unrolled into a queue holding one entry
  // per output cycle; each clock in RUN consumes one entry.
  typedef struct packed {
    logic [1:0]    m;
    logic [SW-1:0] s;
  } ent_t;

  ent_t       q[$];
  logic [1:0] tm[NS];
  int         td[NS];
  int         last_m;
  bit         loop_m;
  bit         running;
  bit         done_e;

  function automatic void build();
    q.delete();
    for (int s = 0; s <= last_m; s++)
      for (int k = 0; k <= td[s]; k++) q.push_back('{m: tm[s], s: SW'(s)});
  endfunction

  initial begin : monitor
    forever begin
      @(posedge clk);
      if (!xrst) begin
        for (int i = 0; i < NS; i++) begin
          tm[i] = 2'd0;
          td[i] = 0;
        end
        last_m  = 0;
        loop_m  = 1'b0;
        running = 1'b0;
        done_e  = 1'b0;
        q.delete();
      end else begin
        done_e = 1'b0;
        if (!running) begin
          if (cfg_we) begin
            tm[cfg_addr] = cfg_mode;
            td[cfg_addr] = int'(cfg_dwell);
          end
          if (start) begin
            running = 1'b1;
            last_m  = int'(cfg_last);
            loop_m  = loop;
            build();
          end
        end else if (stop) begin
          running = 1'b0;
          q.delete();
        end else begin
          void'(q.pop_front());
          if (q.size() == 0) begin
            if (loop_m) build();
            else begin
              running = 1'b0;
              done_e  = 1'b1;
            end
          end
        end
      end
      #1;
      chk("mon_mode", 32'(mode), running ? 32'(q[0].m) : 32'd0);
      chk("mon_slot", 32'(slot), running ? 32'(q[0].s) : 32'd0);
      chk("mon_busy", 32'(busy), 32'(running));
      chk("mon_done", 32'(done), 32'(done_e));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string nm, input int m, input int b, input int d);
    chk({nm, "_mode"}, 32'(mode), 32'(m));
    chk({nm, "_busy"}, 32'(busy), 32'(b));
    chk({nm, "_done"}, 32'(done), 32'(d));
  endtask

  task automatic wr(input int a, input int m, input int d);
    cfg_we    = 1'b1;
    cfg_addr  = SW'(a);
    cfg_mode  = 2'(m);
    cfg_dwell = DW'(d);
    step();
    cfg_we    = 1'b0;
  endtask

  task automatic go(input int lst, input bit lp);
    cfg_last = SW'(lst);
    loop     = lp;
    start    = 1'b1;
    step();
    start    = 1'b0;
  endtask

  int tr[12] = '{1, 1, 1, 2, 3, 3, 1, 1, 1, 2, 3, 3};

  initial begin
    xrst = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_mode = '0; cfg_dwell = '0;
    cfg_last = '0; loop = 1'b0; start = 1'b0; stop = 1'b0;
    step(); step();
    xrst = 1'b1;
    step();
    lit("reset", 0, 0, 0);

    // Cleared table: one-slot run shows mode 0 for one cycle, then done.
    go(0, 1'b0);
    lit("cleared_run", 0, 1, 0);
    step();
    lit("cleared_done", 0, 0, 1);
    step();
    lit("cleared_after", 0, 0, 0);

    wr(0, 1, 2); wr(1, 2, 0); wr(2, 3, 1);
    go(2, 1'b0);
    for (int i = 0; i < 6; i++) begin
      lit("oneshot", tr[i], 1, 0);
      if (i < 5) step();
    end
    step();
    lit("oneshot_done", 0, 0, 1);
    step();
    lit("oneshot_after", 0, 0, 0);

    go(2, 1'b1);
    for (int i = 0; i < 12; i++) begin
      lit("looping", tr[i], 1, 0);
      if (i < 11) step();
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    lit("stopped", 0, 0, 0);

    // Write and start while busy must both be dropped.
    go(2, 1'b0);
    lit("busy_wr", tr[0], 1, 0);
    cfg_we = 1'b1; cfg_addr = 2'd1; cfg_mode = 2'd3; cfg_dwell = 8'd5; start = 1'b1;
    step();
    cfg_we = 1'b0; start = 1'b0;
    for (int i = 1; i < 6; i++) begin
      lit("busy_wr", tr[i], 1, 0);
      if (i < 5) step();
    end
    step();
    lit("busy_wr_done", 0, 0, 1);
    step();
    go(2, 1'b0);
    for (int i = 0; i < 6; i++) begin
      lit("rerun", tr[i], 1, 0);
      step();
    end
    lit("rerun_done", 0, 0, 1);

    wr(0, 2, 255);
    go(0, 1'b0);
    for (int i = 0; i < 256; i++) begin
      lit("maxdwell", 2, 1, 0);
      step();
    end
    lit("maxdwell_done", 0, 0, 1);
    step();

    wr(0, 1, 2);
    go(2, 1'b1);
    step(); step(); step();
    xrst = 1'b0;
    step();
    xrst = 1'b1;
    lit("midrun_reset", 0, 0, 0);
    step();
    lit("midrun_reset_idle", 0, 0, 0);
    go(0, 1'b0);
    lit("post_reset_run", 0, 1, 0);
    step();
    lit("post_reset_done", 0, 0, 1);

    for (int c = 0; c < 4000; c++) begin
      xrst      = ($urandom_range(0, 299) != 0);
      cfg_we    = ($urandom_range(0, 2) == 0);
      cfg_addr  = SW'($urandom);
      cfg_mode  = 2'($urandom);
      cfg_dwell = ($urandom_range(0, 15) == 0) ? DW'($urandom_range(0, 40)) :
                                                 DW'($urandom_range(0, 3));
      cfg_last  = SW'($urandom);
      loop      = 1'($urandom);
      start     = ($urandom_range(0, 5) == 0);
      stop      = ($urandom_range(0, 24) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
